// File: rtl/sdram_pkg.sv
// sdram_pkg
// Shared constants for the single-bank SDRAM core.
//   CMD_*  : encoding of the 3-bit cmd_op field (6 and 7 are reserved)
//   ST_*   : command FSM state encoding
package sdram_pkg;

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;
    localparam logic [2:0] CMD_REF = 3'd5;

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_ACTIVATING  = 3'd1;
    localparam logic [2:0] ST_ACTIVE      = 3'd2;
    localparam logic [2:0] ST_PRECHARGING = 3'd3;
    localparam logic [2:0] ST_REFRESHING  = 3'd4;

endpackage

// File: rtl/sdram_rd_pipe.sv
// sdram_rd_pipe
// DEPTH-stage valid/data shift register carrying read words from the
// array to the rd_valid/rd_data outputs. A synchronous flush clears every
// stage so no read issued before reset is ever delivered.
// Ports:
//   clk, rst           clock, synchronous active-high flush/reset
//   in_valid, in_data  word entering stage 0
//   out_valid          valid bit of the last stage
//   out_data           data of the last stage (holds last delivered word)
module sdram_rd_pipe #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [DEPTH-1:0]  vld;
    logic [DATA_W-1:0] dat [DEPTH];

    // Data stages only advance when the stage behind them holds a valid
    // word, so the final stage keeps the last delivered value when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dat[i] <= '0;
            end
        end else begin
            vld[0] <= in_valid;
            if (in_valid) begin
                dat[0] <= in_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) begin
                    dat[i] <= dat[i-1];
                end
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/sdram_bank_core.sv
// sdram_bank_core
// Single-bank SDRAM storage core: open-row model, command FSM with
// ACT/PRE/REF timing, byte-writable storage array, CAS-latency read pipe
// and refresh-interval tracking. Illegal commands are accepted, discarded
// and flagged with a one-cycle cmd_err pulse.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_op/cmd_row/cmd_col   command opcode and address
//   wr_data/wr_be            write word and byte enables
//   rd_valid/rd_data         read return, CAS_LAT cycles after accept
//   row_open/open_row        ACTIVE indication and the open row
//   refresh_due              refresh interval has elapsed (held)
//   cmd_err                  illegal command pulse
module sdram_bank_core
    import sdram_pkg::*;
#(
    parameter int ROW_AW       = 8,
    parameter int COL_AW       = 6,
    parameter int DATA_W       = 32,
    parameter int T_RCD        = 3,
    parameter int T_RP         = 2,
    parameter int T_RFC        = 6,
    parameter int CAS_LAT      = 2,
    parameter int REF_INTERVAL = 512
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_op,
    input  logic [ROW_AW-1:0]   cmd_row,
    input  logic [COL_AW-1:0]   cmd_col,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    output logic                rd_valid,
    output logic [DATA_W-1:0]   rd_data,
    output logic                row_open,
    output logic [ROW_AW-1:0]   open_row,
    output logic                refresh_due,
    output logic                cmd_err
);

    localparam int WORDS = 2 ** (ROW_AW + COL_AW);
    localparam int BE_W  = DATA_W / 8;
    localparam int T_MAX = (T_RCD > T_RP) ? ((T_RCD > T_RFC) ? T_RCD : T_RFC)
                                          : ((T_RP > T_RFC) ? T_RP : T_RFC);
    // The timer only ever holds N-1, so log2(T_MAX) bits suffice.
    localparam int TMR_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam int REF_W = $clog2(REF_INTERVAL);
    localparam logic [REF_W-1:0] REF_MAX = REF_W'(REF_INTERVAL - 1);

    logic [2:0]               state;
    logic [TMR_W-1:0]         timer;
    logic [REF_W-1:0]         ref_cnt;
    logic                     accept;
    logic                     do_act;
    logic                     do_rd;
    logic                     do_wr;
    logic                     do_pre;
    logic                     do_ref;
    logic                     illegal;
    logic [ROW_AW+COL_AW-1:0] addr;
    logic [DATA_W-1:0]        rd_word;
    logic [DATA_W-1:0]        mem [WORDS];

    assign cmd_ready = (state == ST_IDLE) || (state == ST_ACTIVE);
    assign row_open  = (state == ST_ACTIVE);
    // Commands presented during a reset cycle are ignored entirely.
    assign accept    = cmd_valid && cmd_ready && !rst;
    assign addr      = {open_row, cmd_col};
    assign rd_word   = mem[addr];

    // Command decode. Only IDLE and ACTIVE can accept, so anything not
    // IDLE below is ACTIVE. PRE while IDLE is a harmless no-op.
    always_comb begin
        do_act  = 1'b0;
        do_rd   = 1'b0;
        do_wr   = 1'b0;
        do_pre  = 1'b0;
        do_ref  = 1'b0;
        illegal = 1'b0;
        if (accept) begin
            case (cmd_op)
                CMD_NOP: ;
                CMD_ACT: if (state == ST_IDLE) do_act = 1'b1; else illegal = 1'b1;
                CMD_RD:  if (state == ST_ACTIVE) do_rd = 1'b1; else illegal = 1'b1;
                CMD_WR:  if (state == ST_ACTIVE) do_wr = 1'b1; else illegal = 1'b1;
                CMD_PRE: if (state == ST_ACTIVE) do_pre = 1'b1;
                CMD_REF: if (state == ST_IDLE) do_ref = 1'b1; else illegal = 1'b1;
                default: illegal = 1'b1;
            endcase
        end
    end

    // Command FSM. Timed states load N-1 and leave on the edge where the
    // timer reads zero, giving exactly N cycles with cmd_ready low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            timer    <= '0;
            open_row <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (do_act) begin
                        state    <= ST_ACTIVATING;
                        timer    <= TMR_W'(T_RCD - 1);
                        open_row <= cmd_row;
                    end else if (do_ref) begin
                        state <= ST_REFRESHING;
                        timer <= TMR_W'(T_RFC - 1);
                    end
                end
                ST_ACTIVE: begin
                    if (do_pre) begin
                        state <= ST_PRECHARGING;
                        timer <= TMR_W'(T_RP - 1);
                    end
                end
                ST_ACTIVATING: begin
                    if (timer == '0) state <= ST_ACTIVE;
                    else             timer <= timer - 1'b1;
                end
                ST_PRECHARGING, ST_REFRESHING: begin
                    if (timer == '0) state <= ST_IDLE;
                    else             timer <= timer - 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Refresh tracking: saturating cycle counter, due flag set when it
    // reaches REF_INTERVAL-1 and held until a REF is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_cnt     <= '0;
            refresh_due <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            cmd_err <= illegal;
            if (do_ref) begin
                ref_cnt     <= '0;
                refresh_due <= 1'b0;
            end else if (ref_cnt != REF_MAX) begin
                ref_cnt <= ref_cnt + 1'b1;
                if (ref_cnt == REF_MAX - 1'b1) refresh_due <= 1'b1;
            end
        end
    end

    // Storage array is deliberately not reset so data survives a reset.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            for (int b = 0; b < BE_W; b++) begin
                if (wr_be[b]) mem[addr][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

    sdram_rd_pipe #(
        .DEPTH  (CAS_LAT),
        .DATA_W (DATA_W)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (do_rd),
        .in_data   (rd_word),
        .out_valid (rd_valid),
        .out_data  (rd_data)
    );

endmodule
